// File: rtl/byte_mem_ctrl.sv
// Byte-serial load/store sequencer between the CPU datapath and a 512x8 RAM.
// Define BYTE_MEM_CTRL_UNALIGNED_EN to allow misaligned accesses (address wraps mod 2**ADDR_W).
module byte_mem_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              load_inst,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              fault,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] last;
    logic       sgn;
    logic       st;
  } dec_t;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // last = byte count minus one; a fetch is always an unsigned word load
  function automatic dec_t decode(input logic li, input logic [5:0] op);
    dec_t d;
    d = '{ok: 1'b0, last: 2'd3, sgn: 1'b0, st: 1'b0};
    if (li) begin
      d.ok = 1'b1;
    end else begin
      case (op)
        OP_LB:   d = '{ok: 1'b1, last: 2'd0, sgn: 1'b1, st: 1'b0};
        OP_LH:   d = '{ok: 1'b1, last: 2'd1, sgn: 1'b1, st: 1'b0};
        OP_LW:   d = '{ok: 1'b1, last: 2'd3, sgn: 1'b0, st: 1'b0};
        OP_LBU:  d = '{ok: 1'b1, last: 2'd0, sgn: 1'b0, st: 1'b0};
        OP_LHU:  d = '{ok: 1'b1, last: 2'd1, sgn: 1'b0, st: 1'b0};
        OP_SB:   d = '{ok: 1'b1, last: 2'd0, sgn: 1'b0, st: 1'b1};
        OP_SH:   d = '{ok: 1'b1, last: 2'd1, sgn: 1'b0, st: 1'b1};
        OP_SW:   d = '{ok: 1'b1, last: 2'd3, sgn: 1'b0, st: 1'b1};
        default: d.ok = 1'b0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] last,
                                         input logic sgn);
    logic [31:0] r;
    case (last)
      2'd0:    r = {{24{sgn & raw[7]}}, raw[7:0]};
      2'd1:    r = {{16{sgn & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

`ifndef BYTE_MEM_CTRL_UNALIGNED_EN
  function automatic logic misaligned(input logic [1:0] last, input logic [1:0] a_lo);
    return ((last == 2'd1) && a_lo[0]) || ((last == 2'd3) && (a_lo != 2'b00));
  endfunction
`endif

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [1:0]          last_q, last_d;
  logic                sgn_q, sgn_d;
  logic                st_q, st_d;
  logic                fault_q, fault_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         acc_q, acc_d;
  logic [31:0]         rdata_q, rdata_d;

  dec_t                dec;
  logic                mis;
  logic [31:0]         acc_next;
  logic [1:0]          byte_sel;
  logic [ADDR_W-1:0]   byte_addr;

  assign dec = decode(load_inst, opcode);
`ifdef BYTE_MEM_CTRL_UNALIGNED_EN
  assign mis = 1'b0;
`else
  assign mis = misaligned(dec.last, addr[1:0]);
`endif

  assign acc_next  = {acc_q[23:0], ram_rdata};
  assign byte_sel  = last_q - cnt_q;
  assign byte_addr = base_q + ADDR_W'(cnt_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sgn_d     = sgn_q;
    st_d      = st_q;
    fault_d   = fault_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    acc_d     = acc_q;
    rdata_d   = rdata_q;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          last_d  = dec.last;
          sgn_d   = dec.sgn;
          st_d    = dec.st;
          base_d  = addr;
          wdata_d = wdata;
          cnt_d   = 2'd0;
          acc_d   = 32'h0;
          fault_d = !dec.ok || mis;
          state_d = (!dec.ok || mis) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        ram_addr = byte_addr;
        if (st_q) begin
          ram_we    = 1'b1;
          ram_wdata = wdata_q[{byte_sel, 3'b000} +: 8];
        end else begin
          acc_d = acc_next;
        end
        cnt_d = cnt_q + 2'd1;
        // final byte: the result must be visible in the done cycle itself
        if (cnt_q == last_q) begin
          state_d = S_DONE;
          if (!st_q) rdata_d = extend(acc_next, last_q, sgn_q);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      sgn_q   <= 1'b0;
      st_q    <= 1'b0;
      fault_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= 32'h0;
      acc_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sgn_q   <= sgn_d;
      st_q    <= st_d;
      fault_q <= fault_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign done  = (state_q == S_DONE);
  assign busy  = (state_q != S_IDLE);
  assign fault = (state_q == S_DONE) && fault_q;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl with a behavioural 512x8 RAM.
module tb_byte_mem_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req;
  logic        load_inst;
  logic [5:0]  opcode;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        fault;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:511];
  logic        pk_en;
  logic [8:0]  pk_a;
  logic [7:0]  pk_d;

  int n_chk  = 0;
  int n_fail = 0;

  int   cyc;
  logic flt;
  logic we_seen;

  byte_mem_ctrl #(.ADDR_W(9)) dut (
    .clk(clk), .clr(clr), .req(req), .load_inst(load_inst), .opcode(opcode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .fault(fault), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (pk_en) mem[pk_a] <= pk_d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_a = a; pk_d = d;
    @(posedge clk);
    #1 pk_en = 1'b0;
  endtask

  // Issue one request, scramble inputs after accept, count cycles up to done.
  task automatic access(input logic li, input logic [5:0] op, input logic [8:0] a,
                        input logic [31:0] wd, output int c, output logic f,
                        output logic we);
    @(negedge clk);
    req = 1'b1; load_inst = li; opcode = op; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; load_inst = 1'b0; opcode = 6'b111111; addr = ~a; wdata = ~wd;
    c = 0; we = 1'b0;
    do begin
      @(negedge clk);
      c++;
      if (ram_we) we = 1'b1;
    end while (!done && c < 12);
    f = fault;
    check("busy_in_done", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    clr = 1'b1; req = 1'b0; load_inst = 1'b0; opcode = 6'h00; addr = 9'h0;
    wdata = 32'h0; pk_en = 1'b0; pk_a = 9'h0; pk_d = 8'h00;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {23'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 8; i < 12; i++) poke(i[8:0], 8'h00);
    poke(9'h041, 8'h5A);

    // abort a word store after two bytes
    @(negedge clk);
    req = 1'b1; opcode = 6'b101011; addr = 9'h008; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ram_we", {31'd0, ram_we}, 32'd0);
    check("abort_ram_addr", {23'd0, ram_addr}, 32'd0);
    check("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);
    check("abort_mem8", {24'd0, mem[8]}, 32'hCA);
    check("abort_mem9", {24'd0, mem[9]}, 32'hFE);
    check("abort_mem10", {24'd0, mem[10]}, 32'h00);
    check("abort_mem11", {24'd0, mem[11]}, 32'h00);

    // SW then LW
    access(1'b0, 6'b101011, 9'h010, 32'hDEADBEEF, cyc, flt, we_seen);
    check("sw_cycles", cyc, 5);
    check("sw_fault", {31'd0, flt}, 32'd0);
    check("sw_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
    check("sw_rdata_kept", rdata, 32'h0);
    access(1'b0, 6'b100011, 9'h010, 32'h0, cyc, flt, we_seen);
    check("lw_cycles", cyc, 5);
    check("lw_rdata", rdata, 32'hDEADBEEF);
    check("lw_no_we", {31'd0, we_seen}, 32'd0);

    // byte loads
    poke(9'h020, 8'h80);
    access(1'b0, 6'b100000, 9'h020, 32'h0, cyc, flt, we_seen);
    check("lb_cycles", cyc, 2);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    access(1'b0, 6'b100100, 9'h020, 32'h0, cyc, flt, we_seen);
    check("lbu_cycles", cyc, 2);
    check("lbu_rdata", rdata, 32'h00000080);

    // halfword loads
    poke(9'h030, 8'h80);
    poke(9'h031, 8'h01);
    access(1'b0, 6'b100001, 9'h030, 32'h0, cyc, flt, we_seen);
    check("lh_cycles", cyc, 3);
    check("lh_rdata", rdata, 32'hFFFF8001);
    access(1'b0, 6'b100101, 9'h030, 32'h0, cyc, flt, we_seen);
    check("lhu_cycles", cyc, 3);
    check("lhu_rdata", rdata, 32'h00008001);

    // SB / SH
    access(1'b0, 6'b101000, 9'h040, 32'h123456A5, cyc, flt, we_seen);
    check("sb_cycles", cyc, 2);
    check("sb_mem40", {24'd0, mem[9'h040]}, 32'hA5);
    check("sb_mem41", {24'd0, mem[9'h041]}, 32'h5A);
    access(1'b0, 6'b101001, 9'h050, 32'hFFFF1234, cyc, flt, we_seen);
    check("sh_cycles", cyc, 3);
    check("sh_mem", {16'd0, mem[9'h050], mem[9'h051]}, 32'h00001234);
    check("sh_rdata_kept", rdata, 32'h00008001);

`ifdef BYTE_MEM_CTRL_UNALIGNED_EN
    poke(9'h1FE, 8'h11);
    poke(9'h1FF, 8'h22);
    poke(9'h000, 8'h33);
    poke(9'h001, 8'h44);
    access(1'b0, 6'b100011, 9'h1FE, 32'h0, cyc, flt, we_seen);
    check("lw_wrap_cycles", cyc, 5);
    check("lw_wrap_fault", {31'd0, flt}, 32'd0);
    check("lw_wrap_rdata", rdata, 32'h11223344);
`else
    access(1'b0, 6'b100011, 9'h011, 32'h0, cyc, flt, we_seen);
    check("mis_cycles", cyc, 1);
    check("mis_fault", {31'd0, flt}, 32'd1);
    check("mis_rdata", rdata, 32'h00008001);
    access(1'b0, 6'b101001, 9'h051, 32'h0000ABCD, cyc, flt, we_seen);
    check("mis_sh_fault", {31'd0, flt}, 32'd1);
    check("mis_sh_no_we", {31'd0, we_seen}, 32'd0);
    check("mis_sh_mem", {16'd0, mem[9'h050], mem[9'h051]}, 32'h00001234);
`endif

    // instruction fetch ignores opcode
    poke(9'h004, 8'h01);
    poke(9'h005, 8'h02);
    poke(9'h006, 8'h03);
    poke(9'h007, 8'h84);
    access(1'b1, 6'b000000, 9'h004, 32'h0, cyc, flt, we_seen);
    check("fetch_cycles", cyc, 5);
    check("fetch_fault", {31'd0, flt}, 32'd0);
    check("fetch_rdata", rdata, 32'h01020384);

    // unsupported opcode
    access(1'b0, 6'b111111, 9'h004, 32'h0, cyc, flt, we_seen);
    check("bad_op_cycles", cyc, 1);
    check("bad_op_fault", {31'd0, flt}, 32'd1);
    check("bad_op_no_we", {31'd0, we_seen}, 32'd0);
    check("bad_op_rdata", rdata, 32'h01020384);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_mem_ctrl.md
# byte_mem_ctrl

Multicycle memory sequencer between the CPU datapath and the 512x8 byte-wide RAM array. Accepts one load/store/fetch request at a time, decodes the MIPS opcode into size and signedness, and transfers bytes one per clock in big-endian order. It returns a sign- or zero-extended 32-bit load result and a one-cycle completion pulse to the control unit, replacing the ad-hoc ramDone/MFC timing.

## Interface
Parameters:
- ADDR_W, 9, byte address width (512 bytes)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-high reset
- req  in  1  access request, level, sampled only in IDLE
- load_inst  in  1  instruction fetch; forces word read, opcode ignored
- opcode  in  6  IR[31:26]; selects size/sign/direction
- addr  in  ADDR_W  byte address (MAR output)
- wdata  in  32  store data (register file port B)
- rdata  out  32  load/fetch result, extended
- done  out  1  one-cycle completion pulse
- busy  out  1  high in XFER and DONE
- fault  out  1  valid with done; misaligned or unsupported opcode
- ram_addr  out  ADDR_W  byte address to RAM
- ram_we  out  1  RAM write enable, one byte per cycle
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  8  RAM read byte, combinational from ram_addr

## Operation
- Opcode decode: LB 100000 (1B signed), LH 100001 (2B signed), LW 100011 (4B), LBU 100100 (1B zero), LHU 100101 (2B zero), SB 101000, SH 101001, SW 101011. Any other opcode with load_inst=0 is unsupported.
- States: IDLE, XFER, DONE.
- IDLE: on req=1 at a rising edge, latch addr, size n, sign, direction, wdata; clear byte counter cnt. If unsupported opcode or misaligned (halfword addr[0]!=0, word addr[1:0]!=0) -> DONE with fault=1, no RAM access. Otherwise -> XFER.
- XFER: ram_addr = base + cnt (mod 512). Store: ram_we=1, ram_wdata = byte (n-1-cnt) of wdata (MSB first). Load: ram_rdata shifted into the accumulator at the edge. cnt increments; after byte n-1 -> DONE.
- DONE: done=1 for exactly one cycle; rdata updated for loads (LB/LH sign-extended, LBU/LHU zero-extended, LW/fetch raw); stores and faults leave rdata unchanged. -> IDLE.
- req still high in IDLE after done starts a new access; the control unit deasserts req on done.
- Outside XFER: ram_we=0, ram_addr=0, ram_wdata=0.
- Aligned accesses never cross address 511; wrap only occurs with the configuration below.

## Timing
- Reset: state IDLE, rdata=0, done=0, busy=0, fault=0, ram_we=0, ram_addr=0, ram_wdata=0, cnt=0.
- Accept edge E0. Byte k presented during the cycle after E_k. done high during the cycle after E_n (n=1/2/4): LB/SB 2 cycles, LH/SH 3 cycles, LW/SW/fetch 5 cycles from E0 to the done cycle inclusive.
- Fault: done and fault high during the cycle after E0.
- rdata valid from the done cycle until the next completed load.
- clr mid-XFER: immediate abort, no done; bytes already written remain in RAM.
- opcode/addr/wdata may change after E0 without effect.

## Configuration
- BYTE_MEM_CTRL_UNALIGNED_EN defined: alignment check disabled; misaligned halfword/word accesses proceed byte-serially with ram_addr wrapping mod 512 (word at 510 touches 510, 511, 0, 1); fault only for unsupported opcodes.
- Undefined: misaligned accesses fault as described above.

## Test plan
- Reset mid-SW at 0x008 after 2 bytes -> outputs at reset values, no done, RAM[8..9] written, RAM[10..11] unchanged.
- SW wdata=0xDEADBEEF addr 0x010, then LW addr 0x010 -> RAM[16..19]=DE,AD,BE,EF; rdata=0xDEADBEEF; done 5 cycles after accept.
- RAM[0x020]=0x80: LB -> rdata=0xFFFFFF80; LBU -> 0x00000080; each done in 2 cycles.
- RAM[0x030..31]=0x8001: LH -> 0xFFFF8001; LHU -> 0x00008001; done in 3 cycles.
- LW addr 0x011 -> fault=1 with done 1 cycle after accept, no ram_we, rdata unchanged; with BYTE_MEM_CTRL_UNALIGNED_EN, LW 0x1FE over RAM[510,511,0,1]=11,22,33,44 -> 0x11223344, fault=0.
- load_inst=1 with opcode 000000 addr 0x004 -> word read, no fault; opcode 111111 with load_inst=0 -> fault.
